// File: rtl/ila_capture.sv
// ila_capture: logic-analyzer capture core with masked match/change trigger and pre-trigger window
module ila_capture #(
  parameter int P0_W = 5,
  parameter int P1_W = 4,
  parameter int P2_W = 1,
  parameter int P3_W = 1,
  parameter int P4_W = 1,
  parameter int P5_W = 1,
  parameter int P6_W = 1,
  parameter int P7_W = 1,
  parameter int DEPTH = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int SW = P0_W + P1_W + P2_W + P3_W + P4_W + P5_W + P6_W + P7_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [P0_W-1:0]   probe0,
  input  logic [P1_W-1:0]   probe1,
  input  logic [P2_W-1:0]   probe2,
  input  logic [P3_W-1:0]   probe3,
  input  logic [P4_W-1:0]   probe4,
  input  logic [P5_W-1:0]   probe5,
  input  logic [P6_W-1:0]   probe6,
  input  logic [P7_W-1:0]   probe7,
  input  logic              arm,
  input  logic              trig_mode,
  input  logic [SW-1:0]     trig_mask,
  input  logic [SW-1:0]     trig_value,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [SW-1:0]     rd_data,
  output logic              armed,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_ptr
);
  typedef enum logic [2:0] {IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE} state_t;
  state_t state, nxt;
  logic [SW-1:0] s_q, s_prev;
  logic [SW-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, cnt, post, pre_q, post_init, rd_idx;
  logic trig, we;
  always_comb begin
    trig = trig_mode ? |((s_q ^ s_prev) & trig_mask) : (s_q & trig_mask) == (trig_value & trig_mask);
    post_init = ADDR_W'(DEPTH - 1) - pre_q;
    we = reset && !arm && (state == PRETRIG || state == WAIT_TRIG || state == POSTTRIG);
    rd_idx = trig_ptr - pre_q + rd_addr;
    nxt = arm ? (pretrig != '0 ? PRETRIG : WAIT_TRIG) :
          state == PRETRIG ? (cnt + 1'b1 == pre_q ? WAIT_TRIG : PRETRIG) :
          state == WAIT_TRIG ? (trig ? (post_init == '0 ? DONE : POSTTRIG) : WAIT_TRIG) :
          state == POSTTRIG ? (post == ADDR_W'(1) ? DONE : POSTTRIG) : state;
  end
  always_ff @(posedge clk) begin
    s_q <= {probe7, probe6, probe5, probe4, probe3, probe2, probe1, probe0};
    s_prev <= s_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      cnt <= '0;
      post <= '0;
      pre_q <= '0;
      trig_ptr <= '0;
      triggered <= 1'b0;
    end else begin
      state <= nxt;
      if (arm) begin
        wr_ptr <= '0;
        cnt <= '0;
        triggered <= 1'b0;
        pre_q <= pretrig;
      end else if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        cnt <= state == PRETRIG ? cnt + 1'b1 : cnt;
        post <= state == POSTTRIG ? post - 1'b1 : (state == WAIT_TRIG && trig ? post_init : post);
        if (state == WAIT_TRIG && trig) begin
          trig_ptr <= wr_ptr;
          triggered <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) if (we) ram[wr_ptr] <= s_q;
  always_ff @(posedge clk) rd_data <= reset ? ram[rd_idx] : '0;
  assign armed = state == PRETRIG || state == WAIT_TRIG;
  assign done = state == DONE;
endmodule

// File: tb/tb_ila_capture.sv
// tb_ila_capture: random-stimulus bench checking captures against a window-of-history model
module tb_ila_capture;
  localparam int D = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic arm = 1'b0;
  logic trig_mode = 1'b0;
  logic [4:0] probe0;
  logic [3:0] probe1;
  logic probe2, probe3, probe4, probe5, probe6, probe7;
  logic [14:0] trig_mask = '0;
  logic [14:0] trig_value = '0;
  logic [3:0] pretrig = '0;
  logic [3:0] rd_addr = '0;
  logic [14:0] rd_data;
  logic [3:0] trig_ptr;
  logic armed, triggered, done;
  logic [14:0] p[$];
  int errors = 0;
  int checks = 0;
  int a, de, t;
  always #5 clk = ~clk;
  ila_capture #(.DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .probe0(probe0), .probe1(probe1), .probe2(probe2), .probe3(probe3),
    .probe4(probe4), .probe5(probe5), .probe6(probe6), .probe7(probe7),
    .arm(arm), .trig_mode(trig_mode), .trig_mask(trig_mask), .trig_value(trig_value),
    .pretrig(pretrig), .rd_addr(rd_addr), .rd_data(rd_data),
    .armed(armed), .triggered(triggered), .done(done), .trig_ptr(trig_ptr)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic [14:0] w, input bit a_bit);
    {probe7, probe6, probe5, probe4, probe3, probe2, probe1, probe0} = w;
    arm = a_bit;
    @(posedge clk);
    p.push_back(w);
    #1;
  endtask
  function automatic logic [14:0] gen(input int kind, input int k);
    logic [14:0] w;
    w = 15'($urandom);
    if (kind == 0) w[4:0] = 5'(k);
    if (kind == 1) w[13] = k >= 16;
    if (kind == 2) w[4:0] = 5'h03;
    return w;
  endfunction
  function automatic int find_trig(input int base, input int pre, input bit mode,
                                   input logic [14:0] mask, input logic [14:0] val);
    for (int k = pre; base + k < p.size(); k++) begin
      if (mode ? |((p[base+k] ^ p[base+k-1]) & mask) : (p[base+k] & mask) == (val & mask))
        return k;
    end
    return -1;
  endfunction
  task automatic capture(input bit mode, input logic [14:0] mask, input logic [14:0] val,
                         input logic [3:0] pre, input int kind, input int maxt);
    tick(15'h0, 1'b0);
    trig_mode = mode;
    trig_mask = mask;
    trig_value = val;
    pretrig = pre;
    de = -1;
    for (int k = 0; k < maxt; k++) begin
      tick(gen(kind, k), k == 0);
      if (k == 0) begin
        a = p.size() - 1;
        pretrig = 4'($urandom);
        chk("armed_after_arm", 32'(armed), 32'd1);
        chk("triggered_clear_after_arm", 32'(triggered), 32'd0);
      end
      if (done) begin
        de = p.size() - 1;
        break;
      end
    end
  endtask
  task automatic verify(input string tag, input int pre, input bit mode,
                        input logic [14:0] mask, input logic [14:0] val);
    t = find_trig(a, pre, mode, mask, val);
    chk({tag, "_trigger_found"}, 32'(t >= 0), 32'd1);
    if (t < 0) return;
    chk({tag, "_done_time"}, 32'(de), 32'(a + t + D - pre));
    chk({tag, "_trig_ptr"}, 32'(trig_ptr), 32'(t % D));
    chk({tag, "_triggered"}, 32'(triggered), 32'd1);
    chk({tag, "_armed_low"}, 32'(armed), 32'd0);
    for (int i = 0; i < D; i++) begin
      rd_addr = 4'(i);
      tick(15'($urandom), 1'b0);
      chk($sformatf("%s_rd%0d", tag, i), 32'(rd_data), 32'(p[a + t - pre + i]));
    end
    chk({tag, "_done_held"}, 32'(done), 32'd1);
  endtask
  initial begin
    tick(15'h0, 1'b0);
    tick(15'h0, 1'b0);
    chk("reset_armed", 32'(armed), 32'd0);
    chk("reset_triggered", 32'(triggered), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_trig_ptr", 32'(trig_ptr), 32'd0);
    reset = 1'b1;
    tick(15'h0, 1'b0);
    capture(1'b0, 15'h001f, 15'h0014, 4'd4, 0, 200);
    verify("match", 4, 1'b0, 15'h001f, 15'h0014);
    chk("match_trig_index", 32'(t), 32'd20);
    capture(1'b1, 15'h2000, 15'h0, 4'd0, 1, 200);
    verify("change", 0, 1'b1, 15'h2000, 15'h0);
    chk("change_trig_ptr_zero", 32'(trig_ptr), 32'd0);
    capture(1'b0, 15'h001f, 15'h0003, 4'd15, 2, 200);
    verify("pre15", 15, 1'b0, 15'h001f, 15'h0003);
    chk("pre15_trig_index", 32'(t), 32'd15);
    capture(1'b0, 15'h0, 15'h0, 4'd2, 3, 6);
    chk("rearm_mid_triggered", 32'(triggered), 32'd1);
    chk("rearm_mid_done", 32'(done), 32'd0);
    capture(1'b0, 15'h01e0, 15'h0140, 4'd3, 3, 300);
    verify("rearm", 3, 1'b0, 15'h01e0, 15'h0140);
    capture(1'b0, 15'h0, 15'h0, 4'd5, 3, 10);
    chk("zeromask_triggered", 32'(triggered), 32'd1);
    chk("zeromask_trig_ptr", 32'(trig_ptr), 32'd5);
    chk("zeromask_not_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick(15'h0, 1'b0);
    chk("midreset_armed", 32'(armed), 32'd0);
    chk("midreset_triggered", 32'(triggered), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_trig_ptr", 32'(trig_ptr), 32'd0);
    chk("midreset_rd_data", 32'(rd_data), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ila_capture.md
Name: ila_capture

Overview:
- On-chip logic-analyzer capture core. It samples a concatenated probe word every clock into a circular sample RAM.
- It triggers on a masked value match or a masked change, keeps a programmable number of pre-trigger samples, and fills the rest of the buffer post-trigger.
- It exposes a synchronous readout port ordered oldest-first.
- It sits beside an FSM under debug, e.g. probing its 5-bit state, 4-bit command, start and ready.

Parameters:
- P0_W, 5, width of probe0.
- P1_W, 4, width of probe1.
- P2_W..P5_W, 1 each, widths of probe2..probe5.
- P6_W, 1, width of probe6.
- P7_W, 1, width of probe7.
- DEPTH, 1024, sample buffer depth; power of two, at least 4.
- ADDR_W, log2(DEPTH), buffer address width.
- SW (derived), sum of all P*_W, sample word width.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous reset, active-low.
- probe0..probe7  in  P0_W..P7_W  probe inputs; unused probes are tied to 0.
- arm  in  1  single-cycle pulse that starts a capture.
- trig_mode  in  1  0 = match mode, 1 = change mode.
- trig_mask  in  SW  per-bit trigger enable.
- trig_value  in  SW  compare value for match mode.
- pretrig  in  ADDR_W  number of samples kept before the trigger sample.
- rd_addr  in  ADDR_W  readout index; 0 = oldest sample.
- rd_data  out  SW  readout data, registered.
- armed  out  1  high in PRETRIG and WAIT_TRIG.
- triggered  out  1  high from trigger until the next arm or reset.
- done  out  1  high in DONE.
- trig_ptr  out  ADDR_W  RAM address of the trigger sample.

Behaviour:
- Sample word s = {probe7, probe6, ..., probe0}, with probe0 in the LSBs.
- s is registered into s_q every cycle; s_q is copied into s_prev every cycle. All capture and compare logic uses s_q, giving one cycle of latency from pins.
- Trigger condition:
  - match mode: (s_q & trig_mask) == (trig_value & trig_mask). An all-zero mask triggers on the first eligible cycle.
  - change mode: ((s_q ^ s_prev) & trig_mask) != 0.
- States: IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE.
- Reset (reset==0 at clk edge):
  - state = IDLE.
  - armed, triggered, done = 0; trig_ptr = 0; rd_data = 0.
  - write pointer and counters = 0.
  - RAM contents are not cleared.
- arm in any state (reset deasserted):
  - wr_ptr = 0, cnt = 0, triggered = 0.
  - next state is PRETRIG if pretrig != 0, else WAIT_TRIG.
  - arm has priority over a simultaneous trigger or completion.
  - pretrig is sampled at arm and held internally.
- PRETRIG: write s_q to RAM[wr_ptr], then wr_ptr++ and cnt++. When cnt reaches pretrig, go to WAIT_TRIG. Triggers in PRETRIG are ignored.
- WAIT_TRIG: write s_q every cycle; wr_ptr wraps modulo DEPTH.
  - On trigger: the trigger sample is written at wr_ptr, trig_ptr = wr_ptr, triggered = 1, post = DEPTH-1-pretrig.
  - Then go to POSTTRIG, or straight to DONE if post == 0.
- POSTTRIG: write one sample per cycle, decrement post; after the last post-trigger sample is written, go to DONE.
- DONE: no writes; hold until arm.
- A capture holds exactly DEPTH samples: pretrig before the trigger, the trigger sample, and DEPTH-1-pretrig after.
- Readout:
  - rd_data <= RAM[(trig_ptr - pretrig_held + rd_addr) mod DEPTH] on every clk, one-cycle latency.
  - rd_addr == pretrig returns the trigger sample.
  - Readout before DONE is allowed; data returned before DONE is undefined.
- The RAM is a single write-port, single read-port synchronous block and must be inferable as block RAM.

Test Plan:
- DEPTH=16, reset low for 2 cycles -> armed=0, triggered=0, done=0, rd_data=0, trig_ptr=0.
- Match mode, mask=all 1 on probe0, value probe0=5'h14, pretrig=4; drive probe0 = 0,1,2,... with 5'h14 at step 20 -> done after 11 post samples; rd_addr 0..3 reads probe0 16..19, rd_addr 4 reads 5'h14, rd_addr 15 reads 31 mod 32.
- Change mode, mask on probe6 only, pretrig=0; toggle probe6 once while other probes vary -> trig_ptr=0, rd_addr 0 shows the new probe6 value, triggered=1; changes on other probes before the toggle do not trigger.
- pretrig=15 with a trigger present from arm -> no trigger during the first 15 samples; the trigger is taken in WAIT_TRIG; done asserts the cycle after the trigger write; rd_addr 15 is the trigger sample.
- Re-arm during POSTTRIG -> triggered clears, state returns to PRETRIG, the earlier capture is abandoned, and the new capture completes correctly.
- Match mode with an all-zero mask -> trigger on the first WAIT_TRIG cycle; reset asserted mid-POSTTRIG -> IDLE with all flags 0 on the next cycle.
